// File: rtl/cam_init_seq_if.sv
// Handshake bundle between cam_init_seq (master) and the sensor pins / i2c_config side (slave).
interface cam_init_seq_if;
    logic       cfg_done;
    logic       cfg_error;
    logic       restart;
    logic       cfg_rst;
    logic       cam_pwdn;
    logic       cam_rst_n;
    logic       init_done;
    logic       init_fail;
    logic       cfg_timeout;
    logic [3:0] retry_cnt;

    modport master (
        input  cfg_done, cfg_error, restart,
        output cfg_rst, cam_pwdn, cam_rst_n, init_done, init_fail, cfg_timeout, retry_cnt
    );

    modport slave (
        output cfg_done, cfg_error, restart,
        input  cfg_rst, cam_pwdn, cam_rst_n, init_done, init_fail, cfg_timeout, retry_cnt
    );
endinterface

// File: rtl/cam_init_seq.sv
// Camera power-up sequencer: timed PWDN/RESET/SETTLE phases, then supervises i2c_config with retry.
// Optional S_CONFIG watchdog enabled by defining CAM_INIT_WATCHDOG_EN.
module cam_init_seq #(
    parameter int unsigned T_PWDN_CYC    = 1000,
    parameter int unsigned T_RST_CYC     = 1000,
    parameter int unsigned T_SETTLE_CYC  = 5000,
    parameter int unsigned T_TIMEOUT_CYC = 32'd1 << 24,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic           clk,
    input  logic           rst,
    cam_init_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_PWDN, S_RESET, S_SETTLE, S_CONFIG, S_RETRY, S_DONE, S_FAIL
    } state_e;

    if (T_PWDN_CYC == 0 || T_RST_CYC == 0 || T_SETTLE_CYC == 0 ||
        T_TIMEOUT_CYC == 0 || MAX_RETRY > 15) begin : g_bad_cfg
        $error("cam_init_seq: invalid timing or retry parameters");
    end

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        timeout_q, timeout_d;
    logic        cfg_rst_q, pwdn_q, rst_n_q, done_q, fail_q;
    logic        wd_fire;

`ifdef CAM_INIT_WATCHDOG_EN
    assign wd_fire = (cnt_q == 32'(T_TIMEOUT_CYC - 1));
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        timeout_d = timeout_q;
        case (state_q)
            S_PWDN:   if (cnt_q == 32'(T_PWDN_CYC - 1))   state_d = S_RESET;
            S_RESET:  if (cnt_q == 32'(T_RST_CYC - 1))    state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == 32'(T_SETTLE_CYC - 1)) state_d = S_CONFIG;
            S_CONFIG: begin
                // cfg_done takes priority over a simultaneous watchdog expiry
                if (bus.cfg_done) begin
                    state_d = bus.cfg_error ? S_RETRY : S_DONE;
                end else if (wd_fire) begin
                    timeout_d = 1'b1;
                    state_d   = S_RETRY;
                end
            end
            S_RETRY: begin
                if (retry_q == 4'(MAX_RETRY)) begin
                    state_d = S_FAIL;
                end else begin
                    retry_d = retry_q + 4'd1;
                    state_d = S_PWDN;
                end
            end
            S_DONE, S_FAIL: begin
                if (bus.restart) begin
                    state_d   = S_PWDN;
                    retry_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = S_PWDN;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 32'd1;
    end

    // Pin outputs are decoded from the next state so they change on the entry edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_PWDN;
            cnt_q     <= '0;
            retry_q   <= '0;
            timeout_q <= 1'b0;
            cfg_rst_q <= 1'b1;
            pwdn_q    <= 1'b1;
            rst_n_q   <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            timeout_q <= timeout_d;
            cfg_rst_q <= !(state_d inside {S_CONFIG, S_DONE});
            pwdn_q    <= state_d inside {S_PWDN, S_FAIL};
            rst_n_q   <= state_d inside {S_SETTLE, S_CONFIG, S_RETRY, S_DONE};
            done_q    <= (state_d == S_DONE);
            fail_q    <= (state_d == S_FAIL);
        end
    end

    assign bus.cfg_rst     = cfg_rst_q;
    assign bus.cam_pwdn    = pwdn_q;
    assign bus.cam_rst_n   = rst_n_q;
    assign bus.init_done   = done_q;
    assign bus.init_fail   = fail_q;
    assign bus.cfg_timeout = timeout_q;
    assign bus.retry_cnt   = retry_q;

endmodule

// File: tb/tb_cam_init_seq.sv
// Self-checking bench for cam_init_seq: per-cycle expected pin vectors from tables, plus async reset case.
module tb_cam_init_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cam_init_seq_if bus();

    cam_init_seq #(
        .T_PWDN_CYC   (4),
        .T_RST_CYC    (3),
        .T_SETTLE_CYC (5),
        .T_TIMEOUT_CYC(100),
        .MAX_RETRY    (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // exp layout: {cfg_rst, cam_pwdn, cam_rst_n, init_done, init_fail, cfg_timeout, retry_cnt[3:0]}
    typedef struct {
        int unsigned cyc;
        logic        rs;
        logic        chk;
        logic [9:0]  exp;
    } vec_t;

    vec_t        tbl[$];
    vec_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    function automatic logic [9:0] v(input logic cr, pd, rn, d, f, t, input logic [3:0] rc);
        return {cr, pd, rn, d, f, t, rc};
    endfunction

    function automatic logic [9:0] obs();
        return {bus.cfg_rst, bus.cam_pwdn, bus.cam_rst_n, bus.init_done,
                bus.init_fail, bus.cfg_timeout, bus.retry_cnt};
    endfunction

    task automatic check(input string nm, input int unsigned cyc, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic add(input int unsigned c, input logic rs, input logic chk, input logic [9:0] e);
        vec_t r;
        r.cyc = c; r.rs = rs; r.chk = chk; r.exp = e;
        tbl.push_back(r);
    endtask

    // Responder: i2c_config raises done dly cycles after its reset drops, error bit per pass.
    task automatic run(input string nm, input int unsigned nc, input int unsigned dly, input logic [3:0] errs);
        int unsigned rcnt = 0;
        int unsigned p = 0;
        vec_t e;
        rst = 1'b1;
        bus.cfg_done  = 1'b0;
        bus.cfg_error = 1'b0;
        bus.restart   = 1'b0;
        repeat (2) @(negedge clk);
        foreach (tbl[i]) sb.push_back(tbl[i]);
        rst = 1'b0;
        for (int unsigned k = 0; k < nc; k++) begin
            bus.restart = 1'b0;
            while (sb.size() != 0 && sb[0].cyc == k) begin
                e = sb.pop_front();
                if (e.chk) check(nm, k, obs(), e.exp);
                if (e.rs) bus.restart = 1'b1;
            end
            if (bus.cfg_rst) begin
                if (bus.cfg_done) p++;
                bus.cfg_done  = 1'b0;
                bus.cfg_error = 1'b0;
                rcnt = 0;
            end else begin
                rcnt++;
                if (rcnt >= dly) begin
                    bus.cfg_done  = 1'b1;
                    bus.cfg_error = (p < 4) ? errs[p] : 1'b0;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s unreached cyc=%0d got=none exp=%b", nm, e.cyc, e.exp);
        end
        tbl.delete();
    endtask

    task automatic load_nominal();
        add(0,  0, 1, v(1,1,0,0,0,0,4'd0));
        add(3,  0, 1, v(1,1,0,0,0,0,4'd0));
        add(4,  0, 1, v(1,0,0,0,0,0,4'd0));
        add(6,  0, 1, v(1,0,0,0,0,0,4'd0));
        add(7,  0, 1, v(1,0,1,0,0,0,4'd0));
        add(11, 0, 1, v(1,0,1,0,0,0,4'd0));
        add(12, 0, 1, v(0,0,1,0,0,0,4'd0));
        add(22, 0, 1, v(0,0,1,0,0,0,4'd0));
        add(23, 0, 1, v(0,0,1,1,0,0,4'd0));
    endtask

    initial begin
        // nominal pass, then restart in S_DONE and an ignored restart during S_SETTLE
        load_nominal();
        add(30, 1, 1, v(0,0,1,1,0,0,4'd0));
        add(31, 0, 1, v(1,1,0,0,0,0,4'd0));
        add(35, 0, 1, v(1,0,0,0,0,0,4'd0));
        add(39, 1, 0, '0);
        add(43, 0, 1, v(0,0,1,0,0,0,4'd0));
        add(53, 0, 1, v(0,0,1,0,0,0,4'd0));
        add(54, 0, 1, v(0,0,1,1,0,0,4'd0));
        run("nominal_restart", 60, 11, 4'b0000);

        // every pass fails -> three power cycles then init_fail
        add(22, 0, 1, v(0,0,1,0,0,0,4'd0));
        add(23, 0, 1, v(1,0,1,0,0,0,4'd0));
        add(24, 0, 1, v(1,1,0,0,0,0,4'd1));
        add(48, 0, 1, v(1,1,0,0,0,0,4'd2));
        add(71, 0, 1, v(1,0,1,0,0,0,4'd2));
        add(72, 0, 1, v(1,1,0,0,1,0,4'd2));
        add(79, 0, 1, v(1,1,0,0,1,0,4'd2));
        run("all_fail", 80, 11, 4'b0111);

        // first pass fails, second clean
        add(23, 0, 1, v(1,0,1,0,0,0,4'd0));
        add(24, 0, 1, v(1,1,0,0,0,0,4'd1));
        add(46, 0, 1, v(0,0,1,0,0,0,4'd1));
        add(47, 0, 1, v(0,0,1,1,0,0,4'd1));
        add(59, 0, 1, v(0,0,1,1,0,0,4'd1));
        run("retry_ok", 60, 11, 4'b0001);

        // cfg_done never arrives
`ifdef CAM_INIT_WATCHDOG_EN
        add(111, 0, 1, v(0,0,1,0,0,0,4'd0));
        add(112, 0, 1, v(1,0,1,0,0,1,4'd0));
        add(113, 0, 1, v(1,1,0,0,0,1,4'd1));
        add(125, 0, 1, v(0,0,1,0,0,1,4'd1));
`else
        add(111, 0, 1, v(0,0,1,0,0,0,4'd0));
        add(112, 0, 1, v(0,0,1,0,0,0,4'd0));
        add(129, 0, 1, v(0,0,1,0,0,0,4'd0));
`endif
        run("no_done", 130, 32'hFFFF_FFFF, 4'b0000);

        // async reset in S_CONFIG: outputs return without a clock edge, then nominal timing repeats
        add(15, 0, 1, v(0,0,1,0,0,0,4'd0));
        run("pre_async_rst", 16, 11, 4'b0000);
        #1 rst = 1'b1;
        #1 check("async_rst", 16, obs(), v(1,1,0,0,0,0,4'd0));
        load_nominal();
        run("post_async_rst", 30, 11, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
